// File: rtl/mario_pkg.sv
// ============================================================================
//  Module      : mario_pkg
//  Description : Shared types and constants for the Mario sprite renderer:
//                pose state encoding, facing encoding, ROM select codes,
//                sprite size and transparency key.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mario_pkg;

    localparam int          SPRITE_DIM  = 32;
    localparam logic [11:0] TRANSPARENT = 12'hF0F;

    typedef enum logic [1:0] {
        POSE_IDLE   = 2'd0,
        POSE_WALK_A = 2'd1,
        POSE_WALK_B = 2'd2,
        POSE_JUMP   = 2'd3
    } pose_e;

    typedef enum logic {
        FACE_RIGHT = 1'b0,
        FACE_LEFT  = 1'b1
    } facing_e;

    typedef enum logic [2:0] {
        SEL_JR = 3'd0,
        SEL_JL = 3'd1,
        SEL_WR = 3'd2,
        SEL_WL = 3'd3,
        SEL_IR = 3'd4,
        SEL_IL = 3'd5
    } rom_sel_e;

    // WALK_B deliberately shows the idle image so the walk cycle alternates
    // between the walk and idle frames.
    function automatic rom_sel_e pose_to_sel(input pose_e pose, input facing_e facing);
        rom_sel_e sel;
        case (pose)
            POSE_JUMP:   sel = (facing == FACE_LEFT) ? SEL_JL : SEL_JR;
            POSE_WALK_A: sel = (facing == FACE_LEFT) ? SEL_WL : SEL_WR;
            default:     sel = (facing == FACE_LEFT) ? SEL_IL : SEL_IR;
        endcase
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mario_sprite_renderer_if.sv
// ============================================================================
//  Module      : mario_sprite_renderer_if
//  Description : Bundle of video timing, Mario position/movement, pose ROM
//                bus and pixel output signals around the sprite renderer.
//                master = video/ROM side, slave = renderer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mario_sprite_renderer_if #(
    parameter int ADDR_W  = 10,
    parameter int COLOR_W = 12
);

    logic [9:0]         h_count;
    logic [9:0]         v_count;
    logic               bright;
    logic               frame_tick;
    logic [9:0]         mario_x;
    logic [9:0]         mario_y;
    logic               move_left;
    logic               move_right;
    logic               airborne;

    logic [ADDR_W-1:0]  rom_addr;
    logic [COLOR_W-1:0] rom_jr;
    logic [COLOR_W-1:0] rom_jl;
    logic [COLOR_W-1:0] rom_wr;
    logic [COLOR_W-1:0] rom_wl;
    logic [COLOR_W-1:0] rom_ir;
    logic [COLOR_W-1:0] rom_il;

    logic [COLOR_W-1:0] pixel;
    logic               pixel_valid;

    modport master (
        output h_count, v_count, bright, frame_tick,
        output mario_x, mario_y, move_left, move_right, airborne,
        input  rom_addr,
        output rom_jr, rom_jl, rom_wr, rom_wl, rom_ir, rom_il,
        input  pixel, pixel_valid
    );

    modport slave (
        input  h_count, v_count, bright, frame_tick,
        input  mario_x, mario_y, move_left, move_right, airborne,
        output rom_addr,
        input  rom_jr, rom_jl, rom_wr, rom_wl, rom_ir, rom_il,
        output pixel, pixel_valid
    );

endinterface

`default_nettype wire

// File: rtl/mario_pose_fsm.sv
// ============================================================================
//  Module      : mario_pose_fsm
//  Description : Facing register, pose FSM (IDLE/WALK_A/WALK_B/JUMP) and walk
//                animation counter. Everything updates on frame_tick only, so
//                the pose is frozen for the whole visible frame. Outputs the
//                3-bit pose ROM select code.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mario_pose_fsm
    import mario_pkg::*;
#(
    parameter int WALK_TOGGLE = 8
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     frame_tick_i,
    input  logic     move_left_i,
    input  logic     move_right_i,
    input  logic     airborne_i,
    output rom_sel_e sel_o
);

    localparam int CNT_W = (WALK_TOGGLE > 1) ? $clog2(WALK_TOGGLE) : 1;

    pose_e             state_q, state_d;
    facing_e           facing_q, facing_d;
    logic [CNT_W-1:0]  anim_cnt_q, anim_cnt_d;

    logic one_move;
    assign one_move = move_left_i ^ move_right_i;

    // State, facing and animation counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= POSE_IDLE;
            facing_q   <= FACE_RIGHT;
            anim_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            facing_q   <= facing_d;
            anim_cnt_q <= anim_cnt_d;
        end
    end

    // Next-state: facing follows a single move bit, airborne wins over walking
    always_comb begin
        state_d    = state_q;
        facing_d   = facing_q;
        anim_cnt_d = anim_cnt_q;
        if (frame_tick_i) begin
            if (move_left_i && !move_right_i) begin
                facing_d = FACE_LEFT;
            end else if (move_right_i && !move_left_i) begin
                facing_d = FACE_RIGHT;
            end

            if (airborne_i) begin
                state_d = POSE_JUMP;
            end else if (one_move) begin
                case (state_q)
                    POSE_WALK_A, POSE_WALK_B: begin
                        if (anim_cnt_q == CNT_W'(WALK_TOGGLE - 1)) begin
                            anim_cnt_d = '0;
                            state_d    = (state_q == POSE_WALK_A) ? POSE_WALK_B : POSE_WALK_A;
                        end else begin
                            anim_cnt_d = anim_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d    = POSE_WALK_A;
                        anim_cnt_d = '0;
                    end
                endcase
            end else begin
                state_d    = POSE_IDLE;
                anim_cnt_d = '0;
            end
        end
    end

    // Select code decoded from the registered pose and facing
    always_comb begin
        sel_o = pose_to_sel(state_q, facing_q);
    end

endmodule

`default_nettype wire

// File: rtl/mario_sprite_renderer.sv
// ============================================================================
//  Module      : mario_sprite_renderer
//  Description : Mario sprite renderer. Stage 1 forms the shared pose ROM
//                address from the VGA counters and Mario's position, stage 2
//                is the synchronous ROM read, stage 3 picks the pose ROM and
//                applies the transparency key. Counter-to-pixel latency is 3.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mario_sprite_renderer
    import mario_pkg::*;
#(
    parameter int                 SPRITE_DIM  = mario_pkg::SPRITE_DIM,
    parameter int                 ADDR_W      = 10,
    parameter int                 COLOR_W     = 12,
    parameter logic [COLOR_W-1:0] TRANSPARENT = COLOR_W'(mario_pkg::TRANSPARENT),
    parameter int                 WALK_TOGGLE = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    mario_sprite_renderer_if.slave  bus
);

    localparam int OFS_W = $clog2(SPRITE_DIM);

    rom_sel_e sel;

    mario_pose_fsm #(
        .WALK_TOGGLE (WALK_TOGGLE)
    ) u_pose_fsm (
        .clk          (clk),
        .rst          (rst),
        .frame_tick_i (bus.frame_tick),
        .move_left_i  (bus.move_left),
        .move_right_i (bus.move_right),
        .airborne_i   (bus.airborne),
        .sel_o        (sel)
    );

    // ------------------------------------------------------------------
    // Stage 1: sprite-relative offsets. Computed one bit wider so a
    // counter left of / above Mario goes negative (huge unsigned) instead
    // of wrapping back into the box.
    // ------------------------------------------------------------------
    logic [10:0]        dx, dy;
    logic               in_box;
    logic [ADDR_W-1:0]  rom_addr_d;

    assign dx     = {1'b0, bus.h_count} - {1'b0, bus.mario_x};
    assign dy     = {1'b0, bus.v_count} - {1'b0, bus.mario_y};
    assign in_box = bus.bright && (dx < 11'(SPRITE_DIM)) && (dy < 11'(SPRITE_DIM));

    // Row-major address: dy * SPRITE_DIM + dx, as a concatenation
    assign rom_addr_d = in_box ? ADDR_W'({dy[OFS_W-1:0], dx[OFS_W-1:0]}) : '0;

    logic [ADDR_W-1:0]  rom_addr_q;
    logic               in_box_d1_q, in_box_d2_q;
    rom_sel_e           sel_d1_q, sel_d2_q;

    // Stage 1 register: ROM address plus in-box flag and pose select
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr_q  <= '0;
            in_box_d1_q <= 1'b0;
            sel_d1_q    <= SEL_IR;
        end else begin
            rom_addr_q  <= rom_addr_d;
            in_box_d1_q <= in_box;
            sel_d1_q    <= sel;
        end
    end

    // Stage 2 register: carry in-box and select alongside the ROM read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_box_d2_q <= 1'b0;
            sel_d2_q    <= SEL_IR;
        end else begin
            in_box_d2_q <= in_box_d1_q;
            sel_d2_q    <= sel_d1_q;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: pick the pose ROM that was addressed for this pixel and
    // apply the colour key.
    // ------------------------------------------------------------------
    logic [COLOR_W-1:0] rom_data;
    logic [COLOR_W-1:0] pixel_d, pixel_q;
    logic               pixel_valid_d, pixel_valid_q;

    // Pose ROM data mux driven by the delayed select
    always_comb begin
        rom_data = bus.rom_ir;
        case (sel_d2_q)
            SEL_JR:  rom_data = bus.rom_jr;
            SEL_JL:  rom_data = bus.rom_jl;
            SEL_WR:  rom_data = bus.rom_wr;
            SEL_WL:  rom_data = bus.rom_wl;
            SEL_IR:  rom_data = bus.rom_ir;
            SEL_IL:  rom_data = bus.rom_il;
            default: rom_data = bus.rom_ir;
        endcase
    end

    // Transparency key: the key colour means no Mario pixel here
    always_comb begin
        pixel_valid_d = in_box_d2_q && (rom_data != TRANSPARENT);
        pixel_d       = pixel_valid_d ? rom_data : '0;
    end

    // Stage 3 register: final colour and opaque flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_q       <= '0;
            pixel_valid_q <= 1'b0;
        end else begin
            pixel_q       <= pixel_d;
            pixel_valid_q <= pixel_valid_d;
        end
    end

    assign bus.rom_addr    = rom_addr_q;
    assign bus.pixel       = pixel_q;
    assign bus.pixel_valid = pixel_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mario_sprite_renderer.sv
// ============================================================================
//  Module      : tb_mario_sprite_renderer
//  Description : Self-checking bench for mario_sprite_renderer. Six
//                synchronous pose ROMs with distinct contents, a pose/facing
//                reference model and a pixel expectation pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mario_sprite_renderer;

    localparam int WT  = 8;
    localparam int DIM = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mario_sprite_renderer_if bus ();

    mario_sprite_renderer #(
        .WALK_TOGGLE (WT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ROM k: 0=JR 1=JL 2=WR 3=WL 4=IR 5=IL. Each ROM has its own colour key
    // pattern and its own data so the chosen pose is visible in the pixel.
    function automatic logic [11:0] rom_val(input int k, input logic [9:0] a);
        int v;
        if ((int'(a) % 13) == k + 1) return 12'hF0F;
        v = (int'(a) * 37 + k * 689 + 291) & 'hFFF;
        if (v == 'hF0F) v = v ^ 1;
        return 12'(v);
    endfunction

    // Synchronous pose ROMs
    always @(posedge clk) begin
        bus.rom_jr <= rom_val(0, bus.rom_addr);
        bus.rom_jl <= rom_val(1, bus.rom_addr);
        bus.rom_wr <= rom_val(2, bus.rom_addr);
        bus.rom_wl <= rom_val(3, bus.rom_addr);
        bus.rom_ir <= rom_val(4, bus.rom_addr);
        bus.rom_il <= rom_val(5, bus.rom_addr);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference pose model: kind 0=idle 1=walking 2=jumping
    int m_kind   = 0;
    bit m_left   = 0;
    int m_frames = 0;   // frame_ticks since walking began

    function automatic int model_rom();
        if (m_kind == 2) return m_left ? 1 : 0;
        if (m_kind == 1 && ((m_frames / WT) % 2) == 0) return m_left ? 3 : 2;
        return m_left ? 5 : 4;
    endfunction

    // Expected outputs per sampled pixel, oldest first
    int          q_addr[$];
    bit          q_val[$];
    logic [11:0] q_pix[$];

    task automatic flush_model();
        q_addr = {0, 0, 0};
        q_val  = {0, 0, 0};
        q_pix  = {12'h0, 12'h0, 12'h0};
    endtask

    // Stimulus values for the next step
    int h, v, mx, my;
    bit br, ft, ml, mr, air;

    task automatic step();
        int dx, dy, addr, k;
        bit inb;
        logic [11:0] d;
        @(negedge clk);
        bus.h_count    = 10'(h);
        bus.v_count    = 10'(v);
        bus.mario_x    = 10'(mx);
        bus.mario_y    = 10'(my);
        bus.bright     = br;
        bus.frame_tick = ft;
        bus.move_left  = ml;
        bus.move_right = mr;
        bus.airborne   = air;

        dx   = h - mx;
        dy   = v - my;
        inb  = br && dx >= 0 && dx < DIM && dy >= 0 && dy < DIM;
        addr = inb ? dy * DIM + dx : 0;
        k    = model_rom();
        d    = rom_val(k, 10'(addr));
        q_addr.push_back(addr);
        q_val.push_back(inb && d != 12'hF0F);
        q_pix.push_back((inb && d != 12'hF0F) ? d : 12'h0);
        void'(q_addr.pop_front());
        void'(q_val.pop_front());
        void'(q_pix.pop_front());

        // Pose changes take effect after the edge that samples this tick
        if (ft) begin
            if (ml && !mr) m_left = 1;
            else if (mr && !ml) m_left = 0;
            if (air) m_kind = 2;
            else if (ml != mr) begin
                if (m_kind == 1) m_frames++;
                else begin m_kind = 1; m_frames = 0; end
            end else m_kind = 0;
        end

        @(posedge clk);
        #1;
        chk("rom_addr",    32'(bus.rom_addr),    32'(q_addr[2]));
        chk("pixel_valid", 32'(bus.pixel_valid), 32'(q_val[0]));
        chk("pixel",       32'(bus.pixel),       32'(q_pix[0]));
    endtask

    // Async reset asserted between clock edges
    task automatic mid_reset();
        #1;
        rst = 1'b1;
        #1;
        chk("rst_pixel_valid", 32'(bus.pixel_valid), 32'(0));
        chk("rst_pixel",       32'(bus.pixel),       32'(0));
        chk("rst_rom_addr",    32'(bus.rom_addr),    32'(0));
        m_kind = 0; m_left = 0; m_frames = 0;
        bus.frame_tick = 1'b0;
        bus.bright     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        flush_model();
    endtask

    initial begin
        h = 0; v = 0; mx = 100; my = 200;
        br = 0; ft = 0; ml = 0; mr = 0; air = 0;
        bus.h_count = '0; bus.v_count = '0; bus.mario_x = '0; bus.mario_y = '0;
        bus.bright = 1'b0; bus.frame_tick = 1'b0;
        bus.move_left = 1'b0; bus.move_right = 1'b0; bus.airborne = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rom_addr",    32'(bus.rom_addr),    32'(0));
        chk("reset_pixel",       32'(bus.pixel),       32'(0));
        chk("reset_pixel_valid", 32'(bus.pixel_valid), 32'(0));
        #2;
        rst = 1'b0;
        flush_model();

        // In-box pixel at offset (3,5) -> address 0x0A3, idle-right image
        br = 1; h = 103; v = 205;
        step();
        chk("addr_0A3", 32'(bus.rom_addr), 32'h0A3);
        h = 101; step();            // keyed pixel in the idle-right ROM
        h = 99;  step();            // left of Mario
        h = 131; step();            // dx = 31, last column
        h = 132; step();            // dx = 32, outside
        v = 231; h = 110; step();   // dy = 31
        v = 232; step();            // dy = 32
        mx = 1000; h = 5; v = 210; step();   // mario_x > h_count, no wrap
        mx = 100; h = 104; v = 206; br = 0; step();
        br = 1; repeat (3) step();

        // Walk-left animation: 17 frame ticks
        ml = 1; mr = 0; air = 0;
        for (int t = 0; t < 17; t++) begin
            ft = 1; h = 100 + (t % 30); v = 201; step();
            ft = 0;
            h = 102 + (t % 25); step();
            h = 106; v = 220;   step();
        end

        // Mid-frame stability: move inputs change without a frame_tick
        ml = 0; mr = 1;
        for (int t = 0; t < 6; t++) begin
            mr = t[0]; ml = ~t[0];
            h = 100 + t * 3; v = 200 + t; step();
        end

        // Face right, then airborne with both moves: jump-right
        ml = 0; mr = 1; ft = 1; step();
        ft = 0; repeat (2) step();
        ml = 1; mr = 1; air = 1; ft = 1; h = 112; v = 212; step();
        ft = 0; air = 0; ml = 0; mr = 0;
        for (int t = 0; t < 4; t++) begin h = 100 + t * 7; v = 203 + t; step(); end

        // Randomised frames and pixels
        for (int t = 0; t < 600; t++) begin
            if ((t % 40) == 0) begin
                mx = 8 + $urandom_range(0, 700);
                my = 8 + $urandom_range(0, 400);
            end
            ft  = ($urandom_range(0, 5) == 0);
            ml  = $urandom_range(0, 1);
            mr  = $urandom_range(0, 1);
            air = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 7) != 0);
            h   = mx - 4 + $urandom_range(0, 40);
            v   = my - 4 + $urandom_range(0, 40);
            step();
        end

        // Reset in the middle of an in-box run
        ft = 1; ml = 1; mr = 0; air = 0; br = 1; h = mx + 2; v = my + 2; step();
        ft = 0;
        for (int t = 0; t < 3; t++) begin h = mx + 4 + t; step(); end
        mid_reset();
        ml = 0; mr = 0;
        for (int t = 0; t < 8; t++) begin h = mx + t * 3; v = my + t; step(); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
